// File: rtl/sfx_sequencer.sv
// Pong sound-effect engine: turns one-cycle game event pulses into timed,
// frame-counted square-wave tones on the left/right audio pins.
module sfx_sequencer #(
    parameter int unsigned LOW_HALF     = 32768,
    parameter int unsigned HIGH_HALF    = 16384,
    parameter int unsigned HIT_FRAMES   = 4,
    parameter int unsigned WALL_FRAMES  = 3,
    parameter int unsigned SCORE_FRAMES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic evt_paddle,
    input  logic evt_wall,
    input  logic evt_score,
    input  logic pan_right,
    input  logic stereo_en,
    input  logic mute,
    output logic audio_l,
    output logic audio_r,
    output logic busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HIT     = 3'd1;
    localparam logic [2:0] S_WALL    = 3'd2;
    localparam logic [2:0] S_SCORE_A = 3'd3;
    localparam logic [2:0] S_SCORE_B = 3'd4;

    localparam logic [15:0] LOW_LIM  = 16'(LOW_HALF - 1);
    localparam logic [15:0] HIGH_LIM = 16'(HIGH_HALF - 1);

    logic [2:0]  state_q, state_d;
    logic        phase_q, phase_d;
    logic [15:0] half_q, half_d;
    logic [3:0]  frame_q, frame_d;
    logic        pan_q, pan_d;
    logic        audio_l_q, audio_l_d;
    logic        audio_r_q, audio_r_d;

    logic        active;
    logic [1:0]  cur_prio;
    logic [1:0]  evt_prio;
    logic [2:0]  evt_state;
    logic [3:0]  evt_frames;
    logic        evt_accept;
    logic [15:0] half_lim;
    logic        tone;

    assign active = (state_q != S_IDLE);

    // Priority ranking: score(3) > paddle(2) > wall(1); idle ranks 0 so anything wins.
    always_comb begin
        cur_prio   = 2'd0;
        half_lim   = LOW_LIM;
        evt_prio   = 2'd0;
        evt_state  = S_IDLE;
        evt_frames = 4'd0;
        case (state_q)
            S_HIT:     begin cur_prio = 2'd2; half_lim = LOW_LIM;  end
            S_WALL:    begin cur_prio = 2'd1; half_lim = HIGH_LIM; end
            S_SCORE_A: begin cur_prio = 2'd3; half_lim = HIGH_LIM; end
            S_SCORE_B: begin cur_prio = 2'd3; half_lim = LOW_LIM;  end
            default:   begin cur_prio = 2'd0; half_lim = LOW_LIM;  end
        endcase
        if (evt_score) begin
            evt_prio   = 2'd3;
            evt_state  = S_SCORE_A;
            evt_frames = 4'(SCORE_FRAMES);
        end else if (evt_paddle) begin
            evt_prio   = 2'd2;
            evt_state  = S_HIT;
            evt_frames = 4'(HIT_FRAMES);
        end else if (evt_wall) begin
            evt_prio   = 2'd1;
            evt_state  = S_WALL;
            evt_frames = 4'(WALL_FRAMES);
        end
    end

    assign evt_accept = (evt_prio != 2'd0) && (evt_prio >= cur_prio);

    // An accepted event beats a note-ending frame_tick in the same cycle.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        half_d  = half_q;
        frame_d = frame_q;
        pan_d   = pan_q;
        if (evt_accept) begin
            state_d = evt_state;
            frame_d = evt_frames;
            half_d  = 16'd0;
            phase_d = 1'b0;
            pan_d   = pan_right;
        end else if (active) begin
            if (half_q == half_lim) begin
                half_d  = 16'd0;
                phase_d = ~phase_q;
            end else begin
                half_d = half_q + 16'd1;
            end
            if (frame_tick) begin
                if (frame_q == 4'd1) begin
                    if (state_q == S_SCORE_A) begin
                        state_d = S_SCORE_B;
                        frame_d = 4'(SCORE_FRAMES);
                        half_d  = 16'd0;
                        phase_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        phase_d = 1'b0;
                    end
                end else begin
                    frame_d = frame_q - 4'd1;
                end
            end
        end
    end

    assign tone = phase_q & active & ~mute;

    always_comb begin
        audio_l_d = tone;
        audio_r_d = tone;
        if (stereo_en) begin
            audio_l_d = tone & ~pan_q;
            audio_r_d = tone & pan_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            half_q    <= 16'd0;
            frame_q   <= 4'd0;
            pan_q     <= 1'b0;
            audio_l_q <= 1'b0;
            audio_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            half_q    <= half_d;
            frame_q   <= frame_d;
            pan_q     <= pan_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
        end
    end

    assign audio_l = audio_l_q;
    assign audio_r = audio_r_q;
    assign busy    = active;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with short tones (LOW_HALF=4, HIGH_HALF=2)
// and frame_tick driven by hand every 100 cycles relative to note start.
module tb_sfx_sequencer;

    logic clk;
    logic rst_n;
    logic frame_tick;
    logic evt_paddle;
    logic evt_wall;
    logic evt_score;
    logic pan_right;
    logic stereo_en;
    logic mute;
    logic audio_l;
    logic audio_r;
    logic busy;

    int checks;
    int errors;
    int k;

    sfx_sequencer #(
        .LOW_HALF(4),
        .HIGH_HALF(2),
        .HIT_FRAMES(2),
        .WALL_FRAMES(1),
        .SCORE_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_tick(frame_tick),
        .evt_paddle(evt_paddle),
        .evt_wall(evt_wall),
        .evt_score(evt_score),
        .pan_right(pan_right),
        .stereo_en(stereo_en),
        .mute(mute),
        .audio_l(audio_l),
        .audio_r(audio_r),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s (k=%0d): observed=%b expected=%b", tag, k, observed, expected);
        end
    endtask

    // One clock with the given pulses; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic p, input logic w, input logic s, input logic ft);
        evt_paddle = p;
        evt_wall   = w;
        evt_score  = s;
        frame_tick = ft;
        @(posedge clk);
        #1;
        evt_paddle = 1'b0;
        evt_wall   = 1'b0;
        evt_score  = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic advance(input logic ft);
        applyStimulus(1'b0, 1'b0, 1'b0, ft);
        k++;
    endtask

    // k cycles after the accepting edge the pins show the phase of cycle k-1.
    task automatic check_tone(input string tag, input int half, input logic l_en, input logic r_en);
        logic e;
        e = logic'(((k - 1) / half) % 2);
        checkOutput({tag, "_l"}, audio_l, e & l_en);
        checkOutput({tag, "_r"}, audio_r, e & r_en);
        checkOutput({tag, "_busy"}, busy, 1'b1);
    endtask

    // Plays out a whole note from k=0, frame_tick at every 100th cycle.
    task automatic play_note(input string tag, input int half, input logic l_en, input logic r_en,
                             input int frames);
        for (int f = 1; f <= frames; f++) begin
            for (int i = 0; i < 99; i++) begin
                advance(1'b0);
                check_tone(tag, half, l_en, r_en);
            end
            advance(1'b1);
            if (f < frames) check_tone(tag, half, l_en, r_en);
        end
    endtask

    task automatic check_silent(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            advance(1'b0);
            checkOutput({tag, "_l"}, audio_l, 1'b0);
            checkOutput({tag, "_r"}, audio_r, 1'b0);
            checkOutput({tag, "_busy"}, busy, 1'b0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        k          = 0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        evt_paddle = 1'b0;
        evt_wall   = 1'b0;
        evt_score  = 1'b0;
        pan_right  = 1'b0;
        stereo_en  = 1'b0;
        mute       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_l", audio_l, 1'b0);
        checkOutput("reset_r", audio_r, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_silent("idle", 3);

        // Paddle hit, mono: low tone for two frames.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        k = 0;
        checkOutput("hit_start_busy", busy, 1'b1);
        checkOutput("hit_start_l", audio_l, 1'b0);
        play_note("hit_mono", 4, 1'b1, 1'b1, 2);
        checkOutput("hit_end_busy", busy, 1'b0);
        check_silent("hit_after", 3);

        // Wall bounce panned right; pan_right flips mid-note without effect.
        stereo_en = 1'b1;
        pan_right = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        pan_right = 1'b0;
        k = 0;
        checkOutput("wall_start_busy", busy, 1'b1);
        play_note("wall_pan", 2, 1'b0, 1'b1, 1);
        checkOutput("wall_end_busy", busy, 1'b0);
        check_silent("wall_after", 3);
        stereo_en = 1'b0;

        // Score melody: high note then low note, phase restarting at the boundary.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        k = 0;
        checkOutput("score_start_busy", busy, 1'b1);
        play_note("score_a", 2, 1'b1, 1'b1, 2);
        checkOutput("score_boundary_busy", busy, 1'b1);
        k = 0;
        play_note("score_b", 4, 1'b1, 1'b1, 2);
        checkOutput("score_end_busy", busy, 1'b0);
        check_silent("score_after", 3);

        // Priority while HIT plays: wall ignored, score preempts.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            advance(1'b0);
            check_tone("prio_hit", 4, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        k++;
        check_tone("prio_wall_ignored", 4, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            advance(1'b0);
            check_tone("prio_hit_cont", 4, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        k = 0;
        checkOutput("prio_score_busy", busy, 1'b1);
        for (int i = 0; i < 31; i++) begin
            advance(1'b0);
            check_tone("prio_score_a", 2, 1'b1, 1'b1);
        end

        // Asynchronous reset mid-SCORE_A while the tone is high (k=31).
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_l", audio_l, 1'b0);
        checkOutput("rst_async_r", audio_r, 1'b0);
        checkOutput("rst_async_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_silent("rst_after", 10);

        // Paddle and wall together from IDLE pick HIT; then mute mid-note.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        k = 0;
        checkOutput("both_busy", busy, 1'b1);
        for (int i = 0; i < 20; i++) begin
            advance(1'b0);
            check_tone("both_hit", 4, 1'b1, 1'b1);
        end
        mute = 1'b1;
        for (int f = 1; f <= 2; f++) begin
            while (k < f * 100 - 1) begin
                advance(1'b0);
                checkOutput("mute_l", audio_l, 1'b0);
                checkOutput("mute_r", audio_r, 1'b0);
                checkOutput("mute_busy", busy, 1'b1);
            end
            advance(1'b1);
        end
        checkOutput("mute_end_busy", busy, 1'b0);
        mute = 1'b0;
        check_silent("mute_after", 3);

        // Paddle coinciding with the ending frame_tick of a WALL note.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        k = 0;
        for (int i = 0; i < 99; i++) begin
            advance(1'b0);
            check_tone("bnd_wall", 2, 1'b1, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        k = 0;
        checkOutput("bnd_hit_busy", busy, 1'b1);
        play_note("bnd_hit", 4, 1'b1, 1'b1, 2);
        checkOutput("bnd_end_busy", busy, 1'b0);
        check_silent("bnd_after", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
